lut_dbuf: RTL
=============

# lut_dbuf

Parametrised, double-buffered lookup table with N registered read ports and a sequential auto-incrementing loader. One bank is active and serves all read ports, while a CPU/copro byte stream fills the shadow bank. Banks swap atomically only after a complete table has been loaded, so video or coprocessor datapaths never read a half-written table.

## Interface
- `DW`, 8, data width per entry
- `AW`, 6, address width; depth = 2^AW entries per bank
- `NRD`, 3, number of read ports

- `clk`  in  1  single system clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `load_start`  in  1  pulse; begin loading the shadow bank at entry 0
- `load_we`  in  1  write strobe; one entry per cycle while loading
- `load_din`  in  DW  entry data written with `load_we`
- `swap_req`  in  1  pulse; request that shadow becomes active
- `rd_addr`  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW]
- `rd_data`  out  NRD*DW  packed registered read data, same packing
- `load_busy`  out  1  high in LOADING
- `load_done`  out  1  one-cycle pulse when the last entry is written
- `swap_pending`  out  1  a swap is queued, waiting for load completion
- `active_bank`  out  1  index of the bank serving reads

## Operation
- Storage: 2 banks × 2^AW × DW. Writes go only to bank `!active_bank`. Reads come only from `active_bank`. No read/write collision is possible.
- Reset values: state IDLE, write pointer 0, `active_bank` 0, `swap_pending` 0, `rd_data` all 0, `load_busy` 0, `load_done` 0. RAM contents are not reset.
- FSM states: IDLE, LOADING, READY.
  - IDLE: `load_start` → LOADING with pointer 0. `swap_req` is ignored, since no new table exists. `load_we` is ignored.
  - LOADING: on `load_we`, write `load_din` to shadow[ptr] and increment ptr. On a write with ptr = 2^AW−1, pulse `load_done` and leave the state. If `swap_pending` (or `swap_req` in that same cycle) is set, flip `active_bank`, clear pending and go to IDLE; otherwise go to READY. `swap_req` without final write sets `swap_pending`.
  - READY: `swap_req` → flip `active_bank`, go to IDLE. `load_start` → LOADING with pointer 0, discarding the completed shadow table.
- Priorities:
  - `load_start` beats `load_we` in the same cycle; that write is dropped, ptr = 0.
  - `load_start` during LOADING restarts at 0 and clears `swap_pending`.
  - `swap_req` with `load_start` in READY: the swap executes, then loading starts into the new shadow (the old active bank).
- Pointer: AW bits. It never wraps silently, because the final write always exits LOADING.
- `rst` mid-load: loading is aborted, pending swap is cleared, and `active_bank` returns to 0. Partially written data stays in the RAM but is unused until reloaded.

## Timing
- Read latency is 1 cycle: `rd_addr` sampled at edge k appears on `rd_data` after edge k.
- Swap at edge k: reads sampled at edge k still use the old bank; reads sampled at edge k+1 onward use the new bank.
- Writes: one per cycle at full rate. A full load takes 2^AW `load_we` cycles after `load_start`.
- `load_done`, `active_bank` and `swap_pending` are registered outputs and change only at clock edges.

## Structure
- Package `lut_pkg`: FSM state enum (IDLE, LOADING, READY) and the helper `DEPTH = 1 << AW`, expressed as a parameterised function or localparam.
- Sub-module `lut_bank_ram` (DW, AW, NRD): one bank with one synchronous write port and NRD synchronous read ports, instantiated twice.
- The top level holds the FSM, the pointer, the bank select and the output muxing.

## Test plan
- Reset, then read all ports: `rd_data` = 0. `active_bank` = 0, `load_busy` = 0.
- Load 64 entries (value = addr ^ 8'hA5), then `swap_req`:
  - `load_done` pulses on the 64th write.
  - `active_bank` = 1 one cycle after `swap_req`.
  - Ports 0/1/2 at addrs 0/17/63 return A5/B4/9A after 1 cycle.
- Assert `swap_req` at entry 10 of a second load:
  - `swap_pending` = 1 and reads still return the old table.
  - The swap occurs at the edge of the 64th write. `active_bank` returns to 0 and `swap_pending` clears.
- Assert `load_start` and `load_we` in the same cycle, then `load_start` again mid-load:
  - The write is dropped and ptr restarts at 0.
  - After a full reload, entry 0 holds the first post-start datum.
- Assert `rst` at entry 30 of a load: state IDLE, `active_bank` = 0. A following `swap_req` is ignored.
- With NRD = 4 and DW = 12 (parameter sweep), all four ports read distinct addresses concurrently with correct 1-cycle data.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared types for the double-buffered lookup table: FSM states and the bank depth helper.
// No logic of its own, so it has no latency and no backpressure.
package lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } lut_state_e;

  function automatic int unsigned lut_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/lut_bank_ram.sv
// One LUT bank: a single synchronous write port and NRD synchronous read ports, 1-cycle read latency.
// Always accepts a write and reads every cycle, so it never backpressures.
module lut_bank_ram
  import lut_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 6,
  parameter int NRD = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata
);

  localparam int DEPTH = int'(lut_depth(AW));

  logic [DW-1:0]     mem_q [DEPTH];
  logic [NRD*DW-1:0] rdata_d;
  logic [NRD*DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NRD; i++) begin
      rdata_d[i*DW +: DW] = mem_q[raddr[i*AW +: AW]];
    end
  end

  // Only the read registers are reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lut_dbuf.sv
// Double-buffered LUT: active bank serves NRD registered read ports (1-cycle latency), loader fills the shadow.
// No backpressure: one load write accepted per cycle; swaps wait for a complete table instead of stalling.
module lut_dbuf
  import lut_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 6,
  parameter int NRD = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_we,
  input  logic [DW-1:0]     load_din,
  input  logic              swap_req,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic              load_busy,
  output logic              load_done,
  output logic              swap_pending,
  output logic              active_bank
);

  localparam logic [AW-1:0] LAST_PTR = AW'(lut_depth(AW) - 1);

  lut_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          active_bank_q, active_bank_d;
  logic          swap_pending_q, swap_pending_d;
  logic          load_done_q, load_done_d;
  logic          load_busy_q, load_busy_d;
  logic          rd_sel_q, rd_sel_d;
  logic          wr_en;

  logic [NRD*DW-1:0] bank_rdata [2];

  // load_start wins over a same-cycle load_we, so that write never reaches the RAM.
  assign wr_en = (state_q == ST_LOADING) && load_we && !load_start;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    active_bank_d  = active_bank_q;
    swap_pending_d = swap_pending_q;
    load_done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOADING;
          ptr_d   = '0;
        end
      end
      ST_LOADING: begin
        if (load_start) begin
          ptr_d          = '0;
          swap_pending_d = 1'b0;
        end else if (load_we && (ptr_q == LAST_PTR)) begin
          ptr_d       = '0;
          load_done_d = 1'b1;
          if (swap_pending_q || swap_req) begin
            active_bank_d  = !active_bank_q;
            swap_pending_d = 1'b0;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_READY;
          end
        end else begin
          if (load_we) begin
            ptr_d = ptr_q + AW'(1);
          end
          if (swap_req) begin
            swap_pending_d = 1'b1;
          end
        end
      end
      ST_READY: begin
        // A same-cycle load_start follows the swap, so it fills the bank that just went inactive.
        if (swap_req) begin
          active_bank_d = !active_bank_q;
          state_d       = ST_IDLE;
        end
        if (load_start) begin
          state_d = ST_LOADING;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
    load_busy_d = (state_d == ST_LOADING);
    rd_sel_d    = active_bank_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      load_done_q    <= 1'b0;
      load_busy_q    <= 1'b0;
      rd_sel_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      active_bank_q  <= active_bank_d;
      swap_pending_q <= swap_pending_d;
      load_done_q    <= load_done_d;
      load_busy_q    <= load_busy_d;
      rd_sel_q       <= rd_sel_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    lut_bank_ram #(
      .DW  (DW),
      .AW  (AW),
      .NRD (NRD)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en && (active_bank_q != 1'(b))),
      .waddr (ptr_q),
      .wdata (load_din),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  // rd_sel_q holds the bank that was active when these reads were sampled.
  assign rd_data      = bank_rdata[rd_sel_q];
  assign load_busy    = load_busy_q;
  assign load_done    = load_done_q;
  assign swap_pending = swap_pending_q;
  assign active_bank  = active_bank_q;

endmodule
